// File: rtl/route_sched_if.sv
// Bus between the route sequencer and its neighbours: the UART byte handshake,
// the command handshake toward cmd_cntrl, queue status and FSM debug state.
interface route_sched_if #(
   parameter int DEPTH = 8
);
   logic [7:0]              rx_data;
   logic                    rx_rdy;
   logic                    clr_rx_rdy;
   logic [7:0]              cmd;
   logic                    cmd_rdy;
   logic                    clr_cmd_rdy;
   logic                    in_transit;
   logic                    busy;
   logic [$clog2(DEPTH):0]  q_cnt;
   logic                    q_full;
   logic                    q_empty;
   logic                    ovf;
   logic [2:0]              state_dbg;

   // Handshakes: rx_rdy holds rx_data until clr_rx_rdy is seen at a clock edge;
   // cmd_rdy holds cmd until clr_cmd_rdy is seen at a clock edge.
   modport master (
      input  rx_data, rx_rdy, clr_cmd_rdy, in_transit,
      output clr_rx_rdy, cmd, cmd_rdy, busy, q_cnt, q_full, q_empty, ovf, state_dbg
   );

   modport slave (
      output rx_data, rx_rdy, clr_cmd_rdy, in_transit,
      input  clr_rx_rdy, cmd, cmd_rdy, busy, q_cnt, q_full, q_empty, ovf, state_dbg
   );
endinterface

// File: rtl/route_sched.sv
// Multi-stop route sequencer: queues station IDs from the UART link and issues
// one go command per station to cmd_cntrl, with a dwell between legs.
module route_sched #(
   parameter int DEPTH        = 8,
   parameter int DWELL_CYCLES = 25_000_000
) (
   input logic          clk,
   input logic          rst,
   route_sched_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] ISSUE      = 3'd1;
   localparam logic [2:0] WAIT_START = 3'd2;
   localparam logic [2:0] TRANSIT    = 3'd3;
   localparam logic [2:0] DWELL      = 3'd4;
   localparam logic [2:0] STOP       = 3'd5;

   logic [2:0]    state;
   logic [5:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic [CW-1:0] dwell_cnt;
   logic [7:0]    cmd_q;
   logic          cmd_rdy_q;
   logic          ovf_q;

   logic       consume, abort_hit, start_hit, enq_hit;
   logic       full, empty, pop, push;
   logic [1:0] op;

   always_comb begin
      consume   = bus.rx_rdy && (state != STOP);
      op        = bus.rx_data[7:6];
      abort_hit = consume && (op == 2'b00);
      start_hit = consume && (op == 2'b11);
      enq_hit   = consume && (op == 2'b10);
      full      = (cnt == FULL_CNT);
      empty     = (cnt == '0);
      // An abort in the same cycle as the accept wins: the go is dropped, not popped.
      pop       = (state == ISSUE) && cmd_rdy_q && bus.clr_cmd_rdy && !abort_hit && !empty;
      push      = enq_hit && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.rx_data[5:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ovf_q <= enq_hit && full && !pop;
         if (abort_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   cnt <= cnt + (AW+1)'(1);
               2'b01:   cnt <= cnt - (AW+1)'(1);
               default: cnt <= cnt;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_q     <= 8'h00;
         cmd_rdy_q <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_hit && !empty) state <= ISSUE;
            end
            ISSUE: begin
               if (abort_hit) begin
                  state     <= STOP;
                  cmd_q     <= 8'h00;
                  cmd_rdy_q <= 1'b1;
               end else if (!cmd_rdy_q) begin
                  // First ISSUE cycle presents the head of the queue.
                  cmd_q     <= {2'b01, mem[rd_ptr]};
                  cmd_rdy_q <= 1'b1;
               end else if (bus.clr_cmd_rdy) begin
                  cmd_rdy_q <= 1'b0;
                  state     <= WAIT_START;
               end
            end
            WAIT_START, TRANSIT: begin
               if (abort_hit) begin
                  state     <= STOP;
                  cmd_q     <= 8'h00;
                  cmd_rdy_q <= 1'b1;
               end else if ((state == WAIT_START) && bus.in_transit) begin
                  state <= TRANSIT;
               end else if ((state == TRANSIT) && !bus.in_transit) begin
                  state     <= DWELL;
                  dwell_cnt <= DWELL_LOAD;
               end
            end
            DWELL: begin
               if (abort_hit) begin
                  state     <= IDLE;
                  dwell_cnt <= '0;
               end else if (dwell_cnt == '0) begin
                  state <= empty ? IDLE : ISSUE;
               end else begin
                  dwell_cnt <= dwell_cnt - CW'(1);
               end
            end
            STOP: begin
               if (bus.clr_cmd_rdy) begin
                  cmd_rdy_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.clr_rx_rdy = consume;
   assign bus.cmd        = cmd_q;
   assign bus.cmd_rdy    = cmd_rdy_q;
   assign bus.busy       = (state != IDLE);
   assign bus.q_cnt      = cnt;
   assign bus.q_full     = full;
   assign bus.q_empty    = empty;
   assign bus.ovf        = ovf_q;
   assign bus.state_dbg  = state;
endmodule
